shift_seq: RTL and testbench
============================

Name: shift_seq

Overview:
- Sequencer that sits directly upstream of the team's 4-bit universal shift register and drives its cntrl and d inputs.
- Accepts a parallel word over a valid/ready handshake and issues one parallel-load command.
- Then issues DATA_W single-bit shift commands in the selected direction, paced by a programmable divider, inserting a fill bit on each shift.
- Keeps a shadow copy of the word so it can report each bit as it leaves the register, and pulses done when the word is exhausted.

Parameters:
- DATA_W, 4, word width; must match the downstream register width (minimum 2).
- DIV, 1, clock cycles per shift command (minimum 1); one shift per DIV cycles.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data/in_dir/in_fill are valid.
- in_ready  out  1  sequencer can accept a word.
- in_data  in  DATA_W  word to load into the downstream register.
- in_dir  in  1  0 = shift left (MSB leaves first), 1 = shift right (LSB leaves first).
- in_fill  in  1  bit inserted into the vacated end on every shift.
- cntrl  out  2  downstream command: 00 hold, 01 shift left (fill from d[0]), 10 shift right (fill from d[DATA_W-1]), 11 parallel load of d.
- d  out  DATA_W  downstream data.
- tx_bit  out  1  bit leaving the downstream register in the current shift cycle; 0 otherwise.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last shift.

Behaviour:
- Reset is synchronous and active-high: clk is the only clock; reset is sampled on the rising edge of clk only.
- Reset effects: state=IDLE; divider, bit counter, shadow, dir and fill registers cleared.
- Output values after reset: cntrl=00, d=0, tx_bit=0, busy=0, done=0, in_ready=1.
- in_ready = (state==IDLE) & ~reset.
- All outputs are decoded from registered state only; there is no combinational path from the in_* inputs to any output except in_ready's reset term.
- IDLE: cntrl=00, d=0.
  - On in_valid&in_ready at an edge: capture in_data into the shadow register, capture in_dir and in_fill, then go to LOAD.
- LOAD (exactly 1 cycle): cntrl=11, d=shadow.
  - Next edge: bit counter=DATA_W, divider=DIV-1, go to SHIFT.
- SHIFT:
  - A tick is a cycle with divider==0. Non-tick cycles: cntrl=00, d=0, tx_bit=0, divider decrements.
  - Tick with dir=0: cntrl=01, d[0]=fill, other d bits 0, tx_bit=shadow[DATA_W-1].
  - Tick with dir=1: cntrl=10, d[DATA_W-1]=fill, other d bits 0, tx_bit=shadow[0].
  - At the tick edge: shadow shifts identically to the downstream register, bit counter decrements, divider reloads DIV-1.
  - On the tick where bit counter==1: go to DONE.
  - With DIV=1, every SHIFT cycle is a tick.
- DONE (exactly 1 cycle): done=1, cntrl=00, d=0, in_ready=0. Next edge: go to IDLE.
- Latency:
  - Busy cycles per word = 1 + DATA_W*DIV + 1.
  - First LOAD cycle is the cycle after acceptance.
  - in_ready returns the cycle after DONE, so back-to-back words have at least 1 idle cycle between them.
- in_valid and input changes while busy are ignored; nothing is queued.
- Captured dir/fill are constant for the whole word.
- Reset mid-operation: the next cycle is IDLE with reset outputs; the partial word is abandoned and no done pulse is issued.
- Reset with in_valid high: no capture occurs.
- Counter widths: bit counter is clog2(DATA_W+1) bits; divider is clog2(DIV) bits, minimum 1. No wrap occurs in legal operation.

Test Plan:
- DATA_W=4, DIV=1, in_data=1011, dir=0, fill=0 -> cntrl 11,01,01,01,01,00. tx_bit 1,0,1,1. Downstream q 1011,0110,1100,1000,0000. done high on the cycle after the 4th shift. busy for 6 cycles.
- Same word, dir=1, fill=1 -> cntrl 11,10,10,10,10. tx_bit 1,1,0,1. Downstream q 1011,1101,1110,1111,1111. d=1000 on each shift cycle.
- DIV=3, in_data=0110, dir=0 -> after LOAD, cntrl pattern 00,00,01 repeated 4 times. busy for 14 cycles. tx_bit nonzero only on the 01 cycles (0,1,1,0).
- in_valid held high with changing in_data -> only words present while in_ready=1 are captured. Mid-word data changes do not alter d or tx_bit. The second word's LOAD is exactly 2 cycles after done.
- Reset asserted on the 2nd shift cycle -> next cycle: cntrl=00, d=0, busy=0, in_ready=1, and done never pulses. A new word is then accepted and completes normally.
- Reset held with in_valid=1 -> in_ready=0 and no LOAD. Releasing reset gives in_ready=1, and LOAD follows the accepting edge.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: drives a universal shift register with one parallel load followed by
// DATA_W paced single-bit shifts, reporting each bit as it leaves the register.
module shift_seq #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DIV    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dir,
    input  logic              in_fill,
    output logic [1:0]        cntrl,
    output logic [DATA_W-1:0] d,
    output logic              tx_bit,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(DATA_W);
    localparam logic [DivW-1:0] DivLoad = DivW'(DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              dir_q, dir_d;
    logic              fill_q, fill_d;
    logic              tick;

    assign tick     = (div_q == '0);
    assign in_ready = (state_q == StIdle) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            div_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            dir_q    <= 1'b0;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            dir_q    <= dir_d;
            fill_q   <= fill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dir_d    = dir_q;
        fill_d   = fill_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shadow_d = in_data;
                    dir_d    = in_dir;
                    fill_d   = in_fill;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = CntLoad;
                div_d   = DivLoad;
                state_d = StShift;
            end
            StShift: begin
                if (tick) begin
                    // Shadow mirrors the downstream register so tx_bit stays correct.
                    shadow_d = dir_q ? {fill_q, shadow_q[DATA_W-1:1]}
                                     : {shadow_q[DATA_W-2:0], fill_q};
                    cnt_d    = cnt_q - 1'b1;
                    div_d    = DivLoad;
                    if (cnt_q == CntW'(1)) begin
                        state_d = StDone;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cntrl  = 2'b00;
        d      = '0;
        tx_bit = 1'b0;
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        unique case (state_q)
            StLoad: begin
                cntrl = 2'b11;
                d     = shadow_q;
            end
            StShift: begin
                if (tick) begin
                    if (dir_q) begin
                        cntrl         = 2'b10;
                        d[DATA_W-1]   = fill_q;
                        tx_bit        = shadow_q[0];
                    end else begin
                        cntrl         = 2'b01;
                        d[0]          = fill_q;
                        tx_bit        = shadow_q[DATA_W-1];
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: two sequencers (DIV=1 and DIV=3) share stimulus; each is checked cycle by
// cycle against an expected-output trace built from the word, plus a downstream register model.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_dir;
    logic       in_fill;

    logic       rdy1, tx1, busy1, done1;
    logic [1:0] cntrl1;
    logic [3:0] d1;
    logic       rdy3, tx3, busy3, done3;
    logic [1:0] cntrl3;
    logic [3:0] d3;

    logic [3:0] sreg1 = 4'h0;
    logic [3:0] sreg3 = 4'h0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [9:0] o;   // {cntrl, d, tx_bit, busy, done, in_ready}
        logic       qv;
        logic [3:0] q;
    } exp_t;
    typedef exp_t trace_t[$];

    trace_t q1;
    trace_t q3;

    always #5 clk = ~clk;

    shift_seq #(.DATA_W(4), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_dir(in_dir), .in_fill(in_fill),
        .cntrl(cntrl1), .d(d1), .tx_bit(tx1), .busy(busy1), .done(done1)
    );

    shift_seq #(.DATA_W(4), .DIV(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3),
        .in_data(in_data), .in_dir(in_dir), .in_fill(in_fill),
        .cntrl(cntrl3), .d(d3), .tx_bit(tx3), .busy(busy3), .done(done3)
    );

    // Downstream universal shift registers driven by each sequencer.
    always_ff @(posedge clk) begin
        case (cntrl1)
            2'b01:   sreg1 <= {sreg1[2:0], d1[0]};
            2'b10:   sreg1 <= {d1[3], sreg1[3:1]};
            2'b11:   sreg1 <= d1;
            default: sreg1 <= sreg1;
        endcase
        case (cntrl3)
            2'b01:   sreg3 <= {sreg3[2:0], d3[0]};
            2'b10:   sreg3 <= {d3[3], sreg3[3:1]};
            2'b11:   sreg3 <= d3;
            default: sreg3 <= sreg3;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] mk(input logic [1:0] c, input logic [3:0] dd, input logic tx,
                                      input logic b, input logic dn, input logic r);
        return {c, dd, tx, b, dn, r};
    endfunction

    // Register contents after k shifts of the loaded word, by plain arithmetic.
    function automatic logic [3:0] q_after(input logic [3:0] data, input logic dir,
                                           input logic fill, input int k);
        int v;
        v = int'(data);
        if (!dir) v = (v << k) | (fill ? ((1 << k) - 1) : 0);
        else      v = (v >> k) | (fill ? ((15 << (4 - k)) & 15) : 0);
        return 4'(v & 15);
    endfunction

    function automatic trace_t make_trace(input logic [3:0] data, input logic dir,
                                          input logic fill, input int div);
        trace_t t;
        exp_t   e;
        logic   tx;
        e = '{o: mk(2'b11, data, 1'b0, 1'b1, 1'b0, 1'b0), qv: 1'b0, q: 4'h0};
        t.push_back(e);
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < div - 1; j++) begin
                e = '{o: mk(2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0), qv: 1'b1,
                      q: q_after(data, dir, fill, k - 1)};
                t.push_back(e);
            end
            tx = dir ? data[k-1] : data[4-k];
            e = '{o: mk(dir ? 2'b10 : 2'b01, dir ? {fill, 3'b000} : {3'b000, fill}, tx,
                        1'b1, 1'b0, 1'b0), qv: 1'b1, q: q_after(data, dir, fill, k - 1)};
            t.push_back(e);
        end
        e = '{o: mk(2'b00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0), qv: 1'b1,
              q: q_after(data, dir, fill, 4)};
        t.push_back(e);
        return t;
    endfunction

    // One clock cycle: drive inputs, compare outputs, advance the models at the edge.
    task automatic step(input logic rst, input logic vld, input logic [3:0] dat,
                        input logic dr, input logic fl);
        exp_t e1, e3;
        reset    = rst;
        in_valid = vld;
        in_data  = dat;
        in_dir   = dr;
        in_fill  = fl;
        #1;
        e1 = '{o: mk(2'b00, 4'h0, 1'b0, 1'b0, 1'b0, ~rst), qv: 1'b0, q: 4'h0};
        e3 = e1;
        if (q1.size() != 0) begin
            e1 = q1[0];
            e1.o[0] = 1'b0;
        end
        if (q3.size() != 0) begin
            e3 = q3[0];
            e3.o[0] = 1'b0;
        end
        check_eq("div1_out", 32'({cntrl1, d1, tx1, busy1, done1, rdy1}), 32'(e1.o));
        check_eq("div3_out", 32'({cntrl3, d3, tx3, busy3, done3, rdy3}), 32'(e3.o));
        if (e1.qv) check_eq("div1_q", 32'(sreg1), 32'(e1.q));
        if (e3.qv) check_eq("div3_q", 32'(sreg3), 32'(e3.q));
        @(posedge clk);
        if (rst) q1.delete();
        else if (q1.size() != 0) void'(q1.pop_front());
        else if (vld) q1 = make_trace(dat, dr, fl, 1);
        if (rst) q3.delete();
        else if (q3.size() != 0) void'(q3.pop_front());
        else if (vld) q3 = make_trace(dat, dr, fl, 3);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q1.size() != 0 || q3.size() != 0); i++) begin
            step(1'b0, 1'b0, 4'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        in_dir   = 1'b0;
        in_fill  = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with in_valid high: nothing captured.
        step(1'b1, 1'b1, 4'hB, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hB, 1'b0, 1'b0);

        step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0);
        drain();
        step(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
        drain();
        step(1'b0, 1'b1, 4'b0110, 1'b0, 1'b0);
        drain();

        // in_valid held high with data changing every cycle.
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 4'($urandom), 1'($urandom), 1'($urandom));
        end
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

        // Reset on the second shift cycle of the DIV=1 sequencer.
        step(1'b0, 1'b1, 4'b1001, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b0101, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom));
        end
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
